// File: rtl/tx_buffer_sink.sv
// tx_buffer_sink: USB transmit buffer. A word FIFO is filled from the FD bus
// and drained in frames of 2 or 4 words onto ch_0..ch_3 on each txstrobe.
// Optional build macro TX_UNDERRUN_DETECT_EN enables the sticky tx_underrun
// flag; when it is undefined tx_underrun is tied low.
module tx_buffer_sink #(
  parameter int FIFO_AW   = 10,
  parameter int PKT_WORDS = 256
) (
  input  logic               usbclk,
  input  logic               reset,
  input  logic               bus_reset,
  input  logic [15:0]        usbdata,
  input  logic               WR,
  output logic               have_space,
  input  logic [3:0]         channels,
  input  logic               txstrobe,
  output logic [15:0]        ch_0,
  output logic [15:0]        ch_1,
  output logic [15:0]        ch_2,
  output logic [15:0]        ch_3,
  output logic               frame_valid,
  input  logic               clear_status,
  output logic               tx_overrun,
  output logic               tx_underrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                 LVL_W        = FIFO_AW + 1;
  localparam logic [FIFO_AW:0]   PTR_ONE      = LVL_W'(1);
  localparam logic [FIFO_AW:0]   FULL_LVL     = LVL_W'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0]   SPACE_THRESH = LVL_W'((1 << FIFO_AW) - PKT_WORDS);

  typedef enum logic {ST_IDLE, ST_LOAD} state_t;

  state_t              state_q, state_d;
  logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
  logic                have_space_q, have_space_d;
  logic                pending_q, pending_d;
  logic                frame_valid_q, frame_valid_d;
  logic [3:0][15:0]    ch_q, ch_d;
  logic [3:0][15:0]    shadow_q, shadow_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2:0]          chans_q, chans_d;
  logic                overrun_q, overrun_d;

  logic [15:0]         mem [2**FIFO_AW];
  logic [15:0]         rdata;
  logic [FIFO_AW:0]    level;
  logic [FIFO_AW:0]    level_d;
  logic                full;
  logic                wr_en;
  logic [2:0]          chan_n;
  logic                level_ok;

  // Occupancy, full flag and the normalised frame width (anything but 4 means 2).
  always_comb begin
    level    = wr_ptr_q - rd_ptr_q;
    full     = (level == FULL_LVL);
    wr_en    = WR && !full && !bus_reset;
    chan_n   = (channels == 4'd4) ? 3'd4 : 3'd2;
    level_ok = (level >= LVL_W'(chan_n));
    rdata    = mem[rd_ptr_q[FIFO_AW-1:0]];
  end

  // Word storage; written on accepted writes, read at rd_ptr.
  // NOTE: the storage array has no reset -- flushing the pointers makes old contents unreachable.
  always_ff @(posedge usbclk) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= usbdata;
  end

  // Next-state logic for pointers, frame FSM, outputs and sticky overrun.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pending_d     = pending_q;
    frame_valid_d = 1'b0;
    ch_d          = ch_q;
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;
    chans_d       = chans_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case (state_q)
      ST_IDLE: begin
        if (txstrobe || pending_q) begin
          pending_d = 1'b0;
          if (level_ok) begin
            state_d = ST_LOAD;
            chans_d = chan_n;
            cnt_d   = 2'd0;
          end
        end
      end
      ST_LOAD: begin
        if (txstrobe) pending_d = 1'b1;
        rd_ptr_d         = rd_ptr_q + PTR_ONE;
        shadow_d[cnt_q]  = rdata;
        cnt_d            = cnt_q + 2'd1;
        if ({1'b0, cnt_q} == chans_q - 3'd1) begin
          for (int i = 0; i < 4; i++) begin
            if (3'(i) < chans_q) ch_d[i] = shadow_d[i];
          end
          frame_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    level_d      = wr_ptr_d - rd_ptr_d;
    have_space_d = (level_d <= SPACE_THRESH);

    if (WR && full)        overrun_d = 1'b1;
    else if (clear_status) overrun_d = 1'b0;
    else                   overrun_d = overrun_q;

    if (bus_reset) begin
      state_d       = ST_IDLE;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      pending_d     = 1'b0;
      frame_valid_d = 1'b0;
      ch_d          = '0;
      cnt_d         = 2'd0;
      have_space_d  = 1'b1;
      overrun_d     = 1'b0;
    end
  end

  // State register for everything computed above.
  always_ff @(posedge usbclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      have_space_q  <= 1'b1;
      pending_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      ch_q          <= '0;
      shadow_q      <= '0;
      cnt_q         <= 2'd0;
      chans_q       <= 3'd2;
      overrun_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      have_space_q  <= have_space_d;
      pending_q     <= pending_d;
      frame_valid_q <= frame_valid_d;
      ch_q          <= ch_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
      chans_q       <= chans_d;
      overrun_q     <= overrun_d;
    end
  end

`ifdef TX_UNDERRUN_DETECT_EN
  logic underrun_q, underrun_d;
  logic req_drop;

  // A request seen in IDLE without enough words is discarded and flagged.
  always_comb begin
    req_drop = (state_q == ST_IDLE) && (txstrobe || pending_q) && !level_ok;
    if (bus_reset)         underrun_d = 1'b0;
    else if (req_drop)     underrun_d = 1'b1;
    else if (clear_status) underrun_d = 1'b0;
    else                   underrun_d = underrun_q;
  end

  // Sticky underrun register.
  always_ff @(posedge usbclk or posedge reset) begin
    if (reset) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end

  assign tx_underrun = underrun_q;
`else
  assign tx_underrun = 1'b0;
`endif

  assign have_space  = have_space_q;
  assign frame_valid = frame_valid_q;
  assign tx_overrun  = overrun_q;
  assign fifo_level  = level;
  assign ch_0        = ch_q[0];
  assign ch_1        = ch_q[1];
  assign ch_2        = ch_q[2];
  assign ch_3        = ch_q[3];

endmodule

// File: tb/tb_tx_buffer_sink.sv
// Testbench for tx_buffer_sink: directed sequence with random data, checked
// against a queue-based FIFO model and an expected-channel array.
module tb_tx_buffer_sink;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int PKT   = 256;

  logic        usbclk = 1'b0;
  logic        reset, bus_reset;
  logic [15:0] usbdata;
  logic        WR;
  logic        have_space;
  logic [3:0]  channels;
  logic        txstrobe;
  logic [15:0] ch_0, ch_1, ch_2, ch_3;
  logic        frame_valid;
  logic        clear_status;
  logic        tx_overrun, tx_underrun;
  logic [AW:0] fifo_level;

  tx_buffer_sink #(.FIFO_AW(AW), .PKT_WORDS(PKT)) dut (
    .usbclk(usbclk), .reset(reset), .bus_reset(bus_reset),
    .usbdata(usbdata), .WR(WR), .have_space(have_space),
    .channels(channels), .txstrobe(txstrobe),
    .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_3(ch_3),
    .frame_valid(frame_valid), .clear_status(clear_status),
    .tx_overrun(tx_overrun), .tx_underrun(tx_underrun),
    .fifo_level(fifo_level)
  );

  always #5 usbclk = ~usbclk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents and the words each channel should show.
  logic [15:0] model_q[$];
  logic [15:0] exp_ch[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge usbclk);
    #1;
  endtask

  task automatic check_channels(input string tag);
    check({tag, " ch_0"}, 32'(ch_0), 32'(exp_ch[0]));
    check({tag, " ch_1"}, 32'(ch_1), 32'(exp_ch[1]));
    check({tag, " ch_2"}, 32'(ch_2), 32'(exp_ch[2]));
    check({tag, " ch_3"}, 32'(ch_3), 32'(exp_ch[3]));
  endtask

  // Write n words (sequential from base, or random), checking level and space each cycle.
  task automatic write_words(input int n, input bit rnd, input logic [15:0] base, input bit chk);
    for (int i = 0; i < n; i++) begin
      WR      = 1'b1;
      usbdata = rnd ? 16'($urandom) : base + 16'(i);
      if (model_q.size() < DEPTH) model_q.push_back(usbdata);
      step();
      if (chk) begin
        check("write level", 32'(fifo_level), 32'(model_q.size()));
        check("write have_space", 32'(have_space), 32'(model_q.size() <= DEPTH - PKT));
      end
    end
    WR = 1'b0;
  endtask

  // Model a frame of nch words leaving the FIFO.
  task automatic model_frame(input int nch);
    for (int i = 0; i < nch; i++) exp_ch[i] = model_q.pop_front();
  endtask

  // Step until frame_valid is seen or the budget runs out; n = steps taken.
  task automatic wait_fv(input int budget, output int n);
    n = 0;
    while (!frame_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  // One txstrobe with the given channels value; expects a frame of nch words.
  task automatic do_frame(input logic [3:0] chv, input int nch, input string tag);
    int n;
    channels = chv;
    txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
    check({tag, " fv early"}, 32'(frame_valid), 32'(0));
    wait_fv(20, n);
    check({tag, " latency"}, 32'(n + 1), 32'(nch + 1));
    model_frame(nch);
    check_channels(tag);
  endtask

  task automatic reset_model();
    model_q.delete();
    for (int i = 0; i < 4; i++) exp_ch[i] = 16'h0;
  endtask

  bit exp_under;
  bit fv_seen;
  int n1, n2;

  initial begin
`ifdef TX_UNDERRUN_DETECT_EN
    exp_under = 1'b1;
`else
    exp_under = 1'b0;
`endif
    reset = 1'b1; bus_reset = 1'b0; WR = 1'b0; usbdata = '0;
    channels = 4'd2; txstrobe = 1'b0; clear_status = 1'b0;
    reset_model();
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst level", 32'(fifo_level), 32'(0));
    check("rst have_space", 32'(have_space), 32'(1));
    check("rst frame_valid", 32'(frame_valid), 32'(0));
    check("rst overrun", 32'(tx_overrun), 32'(0));
    check("rst underrun", 32'(tx_underrun), 32'(0));
    check_channels("rst");

    // Request on empty FIFO: discarded, no frame
    channels = 4'd2; txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
    fv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fv_seen |= frame_valid;
      step();
    end
    check("empty no fv", 32'(fv_seen), 32'(0));
    check("empty underrun", 32'(tx_underrun), 32'(exp_under));
    check_channels("empty");
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("underrun cleared", 32'(tx_underrun), 32'(0));

    // One packet of sequential words drained as 128 two-word frames
    write_words(256, 1'b0, 16'h0000, 1'b1);
    for (int f = 0; f < 128; f++) begin
      do_frame(4'd2, 2, "pkt");
      step();
    end
    check("pkt level end", 32'(fifo_level), 32'(0));
    check("pkt have_space end", 32'(have_space), 32'(1));

    // Four-word frame, latency 5
    write_words(8, 1'b1, 16'h0, 1'b1);
    do_frame(4'd4, 4, "ch4 a");
    step();

    // Two strobes one cycle apart with channels=2; ch_2/ch_3 must hold
    write_words(4, 1'b1, 16'h0, 1'b1);
    channels = 4'd2;
    txstrobe = 1'b1;
    step();
    step();
    txstrobe = 1'b0;
    wait_fv(20, n1);
    check("dbl first latency", 32'(n1 + 2), 32'(3));
    model_frame(2);
    check_channels("dbl first");
    step();
    wait_fv(20, n2);
    check("dbl spacing", 32'(n2 + 1), 32'(3));
    model_frame(2);
    check_channels("dbl second");
    step();
    check("dbl level", 32'(fifo_level), 32'(model_q.size()));

    // channels change mid-frame is ignored
    channels = 4'd4;
    txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
    channels = 4'd2;
    wait_fv(20, n1);
    check("midchg latency", 32'(n1 + 1), 32'(5));
    model_frame(4);
    check_channels("midchg");
    step();

    // Illegal channels value acts as 2
    write_words(2, 1'b1, 16'h0, 1'b1);
    do_frame(4'd3, 2, "illegal");
    step();
    check("illegal level", 32'(fifo_level), 32'(0));

    // bus_reset in the middle of a frame
    write_words(8, 1'b1, 16'h0, 1'b1);
    channels = 4'd4;
    txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
    step();
    bus_reset = 1'b1;
    step();
    bus_reset = 1'b0;
    reset_model();
    check("busrst level", 32'(fifo_level), 32'(0));
    check("busrst have_space", 32'(have_space), 32'(1));
    check_channels("busrst");
    fv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fv_seen |= frame_valid;
      step();
    end
    check("busrst no fv", 32'(fv_seen), 32'(0));
    check("busrst level hold", 32'(fifo_level), 32'(0));
    write_words(256, 1'b1, 16'h0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      do_frame(4'd2, 2, "post busrst");
      step();
    end
    check("post busrst level", 32'(fifo_level), 32'(model_q.size()));

    // Fill to full, then overrun and sticky-flag clearing
    bus_reset = 1'b1;
    step();
    bus_reset = 1'b0;
    reset_model();
    write_words(DEPTH, 1'b1, 16'h0, 1'b1);
    check("full overrun none", 32'(tx_overrun), 32'(0));
    write_words(1, 1'b1, 16'h0, 1'b0);
    check("overrun set", 32'(tx_overrun), 32'(1));
    check("overrun level", 32'(fifo_level), 32'(DEPTH));
    check("overrun have_space", 32'(have_space), 32'(0));
    WR = 1'b1; clear_status = 1'b1; usbdata = 16'hBEEF;
    step();
    WR = 1'b0;
    check("clear vs set", 32'(tx_overrun), 32'(1));
    step();
    clear_status = 1'b0;
    check("overrun cleared", 32'(tx_overrun), 32'(0));
    check("full level kept", 32'(fifo_level), 32'(DEPTH));
    do_frame(4'd4, 4, "full drain");
    step();
    check("full drain level", 32'(fifo_level), 32'(model_q.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_buffer_sink.md
TX_BUFFER_SINK -- requirements
Module: tx_buffer_sink

Interface
REQ-001 Parameter: FIFO_AW, default 10, FIFO address width; depth 2^FIFO_AW 16-bit words.
REQ-002 Parameter: PKT_WORDS, default 256, USB packet length in 16-bit words (512 bytes).
REQ-003 usbclk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 bus_reset  in  1  synchronous flush of FIFO, counters and output state machine.
REQ-006 usbdata  in  16  word from USB FD bus.
REQ-007 WR  in  1  write strobe; one word accepted per cycle while high.
REQ-008 have_space  out  1  registered; high when at least PKT_WORDS words are free.
REQ-009 channels  in  4  words per output frame; legal values 2 and 4.
REQ-010 txstrobe  in  1  single-cycle request for the next output frame.
REQ-011 ch_0, ch_1, ch_2, ch_3  out  16 each  registered frame words.
REQ-012 frame_valid  out  1  one-cycle pulse when ch_* update.
REQ-013 clear_status  in  1  clears sticky flags.
REQ-014 tx_overrun  out  1  sticky: write attempted while full.
REQ-015 tx_underrun  out  1  sticky: frame requested with too few words (see REQ-033).
REQ-016 fifo_level  out  FIFO_AW+1  current word occupancy.

Function
REQ-017 Write side: WR high and FIFO not full -> store usbdata at wr_ptr, increment wr_ptr modulo 2^(FIFO_AW+1).
REQ-018 WR high and FIFO full -> word dropped, pointers unchanged, tx_overrun set next cycle.
REQ-019 Level equals wr_ptr minus rd_ptr in FIFO_AW+1 bits; full at 2^FIFO_AW, empty at 0.
REQ-020 have_space registered from next-cycle level: high when level <= 2^FIFO_AW - PKT_WORDS.
REQ-021 Simultaneous write and pop in the same cycle -> level unchanged; both operations performed; full at write-cycle start still drops.
REQ-022 Read side FSM states: IDLE, LOAD.
REQ-023 IDLE: on txstrobe (or pending request) with level >= channels -> enter LOAD, clear pending.
REQ-024 LOAD: pop one word per cycle into a shadow register indexed by word counter 0..channels-1.
REQ-025 After the last pop, ch_0..ch_(channels-1) updated from shadow in one cycle together, frame_valid pulses, return to IDLE.
REQ-026 Frame latency: txstrobe to frame_valid = channels+1 cycles.
REQ-027 channels=2 -> ch_2, ch_3 hold their previous values.
REQ-028 txstrobe during LOAD -> set one-deep pending flag; further txstrobe while pending is set is ignored.
REQ-029 Word order: first FIFO word -> ch_0, second -> ch_1, etc.
REQ-030 channels is sampled on entry to LOAD; changes mid-frame have no effect until the next frame.
REQ-031 Illegal channels value -> treated as 2.
REQ-032 Memory read latency one cycle; pointer arithmetic wraps naturally.
REQ-033 txstrobe in IDLE with level < channels -> no pop, ch_* hold, no frame_valid, request discarded.
REQ-034 clear_status clears both sticky flags; if a set event occurs in the same cycle, the flag stays set.

Reset
REQ-035 reset or bus_reset: wr_ptr=rd_ptr=0, fifo_level=0, have_space=1, FSM=IDLE, pending=0, frame_valid=0, ch_0..ch_3=0, tx_overrun=0, tx_underrun=0.
REQ-036 bus_reset asserted mid-LOAD aborts the frame; ch_* zeroed, no frame_valid.
REQ-037 FIFO memory contents need not be cleared.

Configuration
REQ-038 Macro TX_UNDERRUN_DETECT_EN: defined -> REQ-033 case sets tx_underrun; undefined -> tx_underrun tied 0, no associated logic.

Verification
REQ-039 Reset; write 256 words 0x0000..0x00FF; channels=2; 128 txstrobes spaced 4 cycles -> 128 frame_valid, ch_0/ch_1 = (0,1),(2,3)...(0xFE,0xFF); level ends 0.
REQ-040 Write 1024 words with FIFO_AW=10 -> have_space low after word 769; 1025th WR -> tx_overrun=1, level stays 1024; clear_status -> 0.
REQ-041 channels=4, 8 words loaded, txstrobe -> frame_valid exactly 5 cycles later, ch_0..ch_3 = words 0..3.
REQ-042 Empty FIFO, txstrobe -> no frame_valid; tx_underrun=1 with TX_UNDERRUN_DETECT_EN, 0 without.
REQ-043 Two txstrobes one cycle apart, channels=2, 8 words -> two frames, second frame_valid 3 cycles after the first.
REQ-044 bus_reset asserted during LOAD -> level=0, ch_*=0, FSM IDLE, no frame_valid; subsequent packet write/read behaves as REQ-039.
